simple_rf: RTL and testbench

- Small memory-mapped control/status register file: 64-bit software data bus, 2-bit word address (address bits 4:3), single-cycle registered accesses.
- Sits between a host register-access master and the hardware logic.
- Implements a read-only GUID word, a software-writable node ID, and a 4-field register r1 with mixed software/hardware write rules.
- One address is unmapped and reports an invalid access.

---
 rtl/simple_rf.sv | 98 +++++++++
 tb/tb_simple_rf.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_rf.sv
// simple_rf: 64-bit control/status register file with GUID, node ID and r1.
// Four word slots; slot 3 is unmapped and flags invalid accesses.
module simple_rf (
   input  logic        clk,
   input  logic        res,
   input  logic [4:3]  address,
   input  logic        read_en,
   input  logic        write_en,
   input  logic [63:0] write_data,
   output logic [63:0] read_data,
   output logic        access_complete,
   output logic        invalid_address,
   output logic [15:0] node_id,
   input  logic [23:0] node_guid_next,
   input  logic [15:0] r1_r1_1_next,
   output logic [15:0] r1_r1_1,
   input  logic [15:0] r1_r1_2_next,
   output logic [15:0] r1_r1_2,
   output logic        r1_r1_2_written,
   input  logic [15:0] r1_r1_3_next,
   output logic [15:0] r1_r1_3,
   output logic        r1_r1_3_written,
   input  logic [15:0] r1_r1_4_next,
   input  logic        r1_r1_4_wen,
   output logic [15:0] r1_r1_4
);

   localparam logic [63:0] GUID = 64'h0000_0000_0012_ABCD;

   logic        access;
   logic        rd_only;
   logic        wr_id;
   logic        wr_r1;
   logic        bad_addr;
   logic [63:0] rd_mux;
   logic        guid_unused;

   // The GUID is hard-wired, so its hardware input is deliberately dropped.
   assign guid_unused = ^node_guid_next;

   assign access   = read_en | write_en;
   assign rd_only  = read_en & ~write_en;
   assign bad_addr = (address == 2'd3);
   assign wr_id    = write_en & (address == 2'd1);
   assign wr_r1    = write_en & (address == 2'd2);

   // Select the word presented on a read; unmapped slot reads as zero.
   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux = GUID;
         2'd1:    rd_mux = {48'd0, node_id};
         2'd2:    rd_mux = {r1_r1_4, r1_r1_3, r1_r1_2, r1_r1_1};
         default: rd_mux = '0;
      endcase
   end

   // Access handshake, read capture and register storage.
   always_ff @(posedge clk) begin
      if (res) begin
         read_data       <= '0;
         access_complete <= 1'b0;
         invalid_address <= 1'b0;
         node_id         <= '0;
         r1_r1_1         <= '0;
         r1_r1_2         <= '0;
         r1_r1_3         <= '0;
         r1_r1_4         <= '0;
         r1_r1_2_written <= 1'b0;
         r1_r1_3_written <= 1'b0;
      end else begin
         access_complete <= access;
         invalid_address <= access & bad_addr;
         if (rd_only) begin
            read_data <= rd_mux;
         end
         if (wr_id) begin
            node_id <= write_data[15:0];
         end
         if (wr_r1) begin
            r1_r1_1 <= write_data[15:0];
            r1_r1_2 <= write_data[31:16];
            r1_r1_3 <= write_data[47:32];
            r1_r1_4 <= write_data[63:48];
         end else begin
            r1_r1_1 <= r1_r1_1_next;
            r1_r1_2 <= r1_r1_2_next;
            r1_r1_3 <= r1_r1_3_next;
            if (r1_r1_4_wen) begin
               r1_r1_4 <= r1_r1_4_next;
            end
         end
         r1_r1_2_written <= wr_r1;
         r1_r1_3_written <= wr_r1;
      end
   end

endmodule

// File: tb/tb_simple_rf.sv
// tb_simple_rf: directed vectors for simple_rf.
// Access responses are queued at issue and popped by a monitor.
module tb_simple_rf;

   typedef struct {
      logic        chk_rd;
      logic [63:0] rd;
      logic        inv;
   } exp_t;

   logic        clk = 1'b0;
   logic        res;
   logic [1:0]  address;
   logic        read_en;
   logic        write_en;
   logic [63:0] write_data;
   logic [63:0] read_data;
   logic        access_complete;
   logic        invalid_address;
   logic [15:0] node_id;
   logic [23:0] node_guid_next;
   logic [15:0] r1_1_next, r1_2_next, r1_3_next, r1_4_next;
   logic [15:0] r1_1, r1_2, r1_3, r1_4;
   logic        r1_4_wen;
   logic        r1_2_written, r1_3_written;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   localparam logic [63:0] PAT = 64'h555A_AA55_5AAA_555A;

   simple_rf dut (
      .clk(clk),
      .res(res),
      .address(address),
      .read_en(read_en),
      .write_en(write_en),
      .write_data(write_data),
      .read_data(read_data),
      .access_complete(access_complete),
      .invalid_address(invalid_address),
      .node_id(node_id),
      .node_guid_next(node_guid_next),
      .r1_r1_1_next(r1_1_next),
      .r1_r1_1(r1_1),
      .r1_r1_2_next(r1_2_next),
      .r1_r1_2(r1_2),
      .r1_r1_2_written(r1_2_written),
      .r1_r1_3_next(r1_3_next),
      .r1_r1_3(r1_3),
      .r1_r1_3_written(r1_3_written),
      .r1_r1_4_next(r1_4_next),
      .r1_r1_4_wen(r1_4_wen),
      .r1_r1_4(r1_4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of strobes; queue the response it must produce.
   task automatic op(input logic we, input logic re, input logic [1:0] a,
                     input logic [63:0] wd, input logic chk_rd,
                     input logic [63:0] rd);
      exp_t e;
      @(negedge clk);
      write_en   = we;
      read_en    = re;
      address    = a;
      write_data = wd;
      if ((we | re) && !res) begin
         e.chk_rd = chk_rd;
         e.rd     = rd;
         e.inv    = (a == 2'd3);
         exp_q.push_back(e);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every acknowledged access must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (access_complete === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("invalid_address", {63'd0, invalid_address}, {63'd0, e.inv});
            if (e.chk_rd) begin
               chk("read_data", read_data, e.rd);
            end
         end
      end else if (!res) begin
         chk("idle_invalid", {63'd0, invalid_address}, 64'd0);
      end
   end

   initial begin
      res = 1'b1;
      address = '0;
      read_en = 1'b0;
      write_en = 1'b0;
      write_data = '0;
      node_guid_next = 24'hFFFFFF;
      r1_1_next = '0;
      r1_2_next = '0;
      r1_3_next = '0;
      r1_4_next = '0;
      r1_4_wen = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_read_data", read_data, 64'd0);
      chk("rst_ack", {63'd0, access_complete}, 64'd0);
      chk("rst_node_id", {48'd0, node_id}, 64'd0);
      chk("rst_r1", {r1_4, r1_3, r1_2, r1_1}, 64'd0);
      chk("rst_written", {62'd0, r1_2_written, r1_3_written}, 64'd0);
      @(negedge clk);
      res = 1'b0;

      op(1, 0, 0, PAT, 0, 0);
      settle();
      op(1, 0, 1, PAT, 0, 0);
      settle();
      chk("node_id_wr", {48'd0, node_id}, 64'h555A);
      op(1, 0, 2, PAT, 0, 0);
      settle();
      chk("r1_1_wr", {48'd0, r1_1}, 64'h555A);
      chk("r1_2_wr", {48'd0, r1_2}, 64'h5AAA);
      chk("r1_3_wr", {48'd0, r1_3}, 64'hAA55);
      chk("r1_4_wr", {48'd0, r1_4}, 64'h555A);
      chk("written_hi", {62'd0, r1_2_written, r1_3_written}, 64'd3);
      op(1, 0, 3, PAT, 0, 0);
      settle();
      chk("written_lo", {62'd0, r1_2_written, r1_3_written}, 64'd0);
      chk("r1_hw_zero", {48'd0, r1_3, r1_2, r1_1}, 64'd0);
      chk("r1_4_hold", {48'd0, r1_4}, 64'h555A);
      chk("node_id_hold", {48'd0, node_id}, 64'h555A);

      op(0, 0, 0, 0, 0, 0);
      settle();
      chk("idle_ack", {63'd0, access_complete}, 64'd0);
      r1_4_wen = 1'b1;
      op(0, 0, 0, 0, 0, 0);
      settle();
      r1_4_wen = 1'b0;
      chk("r1_4_hw", {48'd0, r1_4}, 64'd0);

      op(0, 1, 0, 0, 1, 64'h0000_0000_0012_ABCD);
      op(0, 1, 1, 0, 1, 64'h0000_0000_0000_555A);
      op(0, 1, 2, 0, 1, 64'd0);
      op(0, 1, 3, 0, 1, 64'd0);
      settle();

      r1_1_next = 16'h1234;
      op(1, 0, 2, 64'h0000_0000_0000_BEEF, 0, 0);
      settle();
      chk("sw_beats_hw", {48'd0, r1_1}, 64'hBEEF);
      op(0, 0, 0, 0, 0, 0);
      settle();
      chk("hw_after_sw", {48'd0, r1_1}, 64'h1234);

      r1_4_wen = 1'b1;
      r1_4_next = 16'h7777;
      op(1, 0, 2, 64'h9999_0000_0000_0000, 0, 0);
      settle();
      chk("sw_beats_wen", {48'd0, r1_4}, 64'h9999);
      op(0, 0, 0, 0, 0, 0);
      settle();
      chk("wen_load", {48'd0, r1_4}, 64'h7777);
      r1_4_wen = 1'b0;

      op(0, 1, 0, 0, 1, 64'h0000_0000_0012_ABCD);
      op(1, 1, 1, 64'h0000_0000_0000_C0DE, 1, 64'h0000_0000_0012_ABCD);
      settle();
      chk("rw_is_write", {48'd0, node_id}, 64'hC0DE);

      res = 1'b1;
      op(1, 0, 1, 64'h0000_0000_0000_FFFF, 0, 0);
      settle();
      chk("rst_mid_node_id", {48'd0, node_id}, 64'd0);
      chk("rst_mid_ack", {63'd0, access_complete}, 64'd0);
      @(negedge clk);
      res = 1'b0;
      write_en = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
